// File: rtl/alu_pkg.sv
// Shared encodings for the 16-bit ALU function units and their dispatcher.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    function automatic logic [3:0] unit_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/alu_result_mux.sv
// Combinational 4:1 select of unit result and result-valid flag.
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] arith_out,
    input  logic [W-1:0] logic_out,
    input  logic [W-1:0] cmp_out,
    input  logic [W-1:0] shift_out,
    input  logic         arith_flag,
    input  logic         logic_flag,
    input  logic         cmp_flag,
    input  logic         shift_flag,
    output logic [W-1:0] out,
    output logic         flag
);

    always_comb begin
        out  = arith_out;
        flag = arith_flag;
        unique case (sel)
            UNIT_ARITH: begin out = arith_out; flag = arith_flag; end
            UNIT_LOGIC: begin out = logic_out; flag = logic_flag; end
            UNIT_CMP:   begin out = cmp_out;   flag = cmp_flag;   end
            UNIT_SHIFT: begin out = shift_out; flag = shift_flag; end
            default:    begin out = arith_out; flag = arith_flag; end
        endcase
    end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Issues one command to an ALU unit, waits its latency, returns the result.
// Define ALU_CMD_SKID_EN for a one-entry command holding register.
module alu_op_dispatcher
    import alu_pkg::*;
#(
    parameter int Data_In_Width = ALU_W,
    parameter int Unit_Latency  = 1
) (
    input  logic                     CLK_in,
    input  logic                     RST_in,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [Data_In_Width-1:0] cmd_A,
    input  logic [Data_In_Width-1:0] cmd_B,
    input  logic [3:0]               cmd_fun,
    output logic [Data_In_Width-1:0] A_out,
    output logic [Data_In_Width-1:0] B_out,
    output logic [3:0]               alu_fun_out,
    output logic                     arith_En,
    output logic                     logic_En,
    output logic                     cmp_En,
    output logic                     shift_En,
    input  logic [Data_In_Width-1:0] arith_out,
    input  logic [Data_In_Width-1:0] logic_out,
    input  logic [Data_In_Width-1:0] cmp_out,
    input  logic [Data_In_Width-1:0] shift_out,
    input  logic                     arith_flag,
    input  logic                     logic_flag,
    input  logic                     cmp_flag,
    input  logic                     shift_flag,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [Data_In_Width-1:0] res_data,
    output logic [1:0]               res_unit,
    output logic                     res_err
);

    localparam int W  = Data_In_Width;
    localparam int CW = (Unit_Latency < 2) ? 1 : $clog2(Unit_Latency + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(Unit_Latency);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]     fun_q, fun_d;
    logic [3:0]     en_q, en_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic [1:0]     res_unit_q, res_unit_d;
    logic           res_err_q, res_err_d;

    logic [W-1:0]   mux_out;
    logic           mux_flag;
    logic           accept, res_hs, issue;
    logic [W-1:0]   iss_a, iss_b;
    logic [3:0]     iss_fun;

`ifdef ALU_CMD_SKID_EN
    logic           skid_full_q, skid_full_d;
    logic [W-1:0]   skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic [3:0]     skid_fun_q, skid_fun_d;

    assign cmd_ready = !skid_full_q;
`else
    assign cmd_ready = (state_q == ST_IDLE);
`endif

    assign accept = cmd_valid && cmd_ready;
    assign res_hs = res_valid_q && res_ready;

    alu_result_mux #(.W(W)) u_mux (
        .sel        (fun_q[3:2]),
        .arith_out  (arith_out),
        .logic_out  (logic_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .arith_flag (arith_flag),
        .logic_flag (logic_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag),
        .out        (mux_out),
        .flag       (mux_flag)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        fun_d       = fun_q;
        en_d        = en_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_unit_d  = res_unit_q;
        res_err_d   = res_err_q;
        issue       = 1'b0;
        iss_a       = cmd_A;
        iss_b       = cmd_B;
        iss_fun     = cmd_fun;
`ifdef ALU_CMD_SKID_EN
        skid_full_d = skid_full_q;
        skid_a_d    = skid_a_q;
        skid_b_d    = skid_b_q;
        skid_fun_d  = skid_fun_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (accept) issue = 1'b1;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    res_valid_d = 1'b1;
                    res_data_d  = mux_flag ? mux_out : '0;
                    res_err_d   = !mux_flag;
                    res_unit_d  = fun_q[3:2];
                    en_d        = '0;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_hs) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    state_d     = ST_IDLE;
`ifdef ALU_CMD_SKID_EN
                    // A held command takes priority over a new arrival
                    if (skid_full_q) begin
                        issue       = 1'b1;
                        iss_a       = skid_a_q;
                        iss_b       = skid_b_q;
                        iss_fun     = skid_fun_q;
                        skid_full_d = 1'b0;
                    end else if (accept) begin
                        issue = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef ALU_CMD_SKID_EN
        if (accept && !issue && state_q != ST_IDLE) begin
            skid_full_d = 1'b1;
            skid_a_d    = cmd_A;
            skid_b_d    = cmd_B;
            skid_fun_d  = cmd_fun;
        end
`endif

        if (issue) begin
            a_d     = iss_a;
            b_d     = iss_b;
            fun_d   = iss_fun;
            en_d    = unit_onehot(iss_fun[3:2]);
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
        end
    end

    always_ff @(posedge CLK_in or posedge RST_in) begin
        if (RST_in) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            en_q        <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_unit_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            fun_q       <= fun_d;
            en_q        <= en_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_unit_q  <= res_unit_d;
            res_err_q   <= res_err_d;
        end
    end

`ifdef ALU_CMD_SKID_EN
    always_ff @(posedge CLK_in or posedge RST_in) begin
        if (RST_in) begin
            skid_full_q <= 1'b0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
            skid_fun_q  <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_a_q    <= skid_a_d;
            skid_b_q    <= skid_b_d;
            skid_fun_q  <= skid_fun_d;
        end
    end
`endif

    assign A_out       = a_q;
    assign B_out       = b_q;
    assign alu_fun_out = fun_q;
    assign arith_En    = en_q[0];
    assign logic_En    = en_q[1];
    assign cmp_En      = en_q[2];
    assign shift_En    = en_q[3];
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_unit    = res_unit_q;
    assign res_err     = res_err_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Randomized bench for alu_op_dispatcher with behavioural unit models and scoreboard.
module tb_alu_op_dispatcher;

`ifdef ALU_CMD_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        CLK_in = 1'b0;
    logic        RST_in = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_A = '0, cmd_B = '0;
    logic [3:0]  cmd_fun = '0;
    logic [15:0] A_out, B_out;
    logic [3:0]  alu_fun_out;
    logic        arith_En, logic_En, cmp_En, shift_En;
    logic        res_valid, res_err;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [1:0]  res_unit;

    logic [15:0] uo [4];
    logic [3:0]  uf = '0;
    logic [3:0]  flag_mode = 4'hF;
    logic [3:0]  en;

    int n_chk = 0;
    int n_fail = 0;

    assign en = {shift_En, cmp_En, logic_En, arith_En};

    always #5 CLK_in = ~CLK_in;

    alu_op_dispatcher dut (
        .CLK_in(CLK_in), .RST_in(RST_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_fun(cmd_fun),
        .A_out(A_out), .B_out(B_out), .alu_fun_out(alu_fun_out),
        .arith_En(arith_En), .logic_En(logic_En),
        .cmp_En(cmp_En), .shift_En(shift_En),
        .arith_out(uo[0]), .logic_out(uo[1]),
        .cmp_out(uo[2]), .shift_out(uo[3]),
        .arith_flag(uf[0]), .logic_flag(uf[1]),
        .cmp_flag(uf[2]), .shift_flag(uf[3]),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_unit(res_unit), .res_err(res_err)
    );

    function automatic logic [15:0] ref_op(input logic [3:0] f,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [3:0]  s;
        logic [15:0] r;
        s = b[3:0];
        case (f)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a + 16'd1;
            4'b0011: r = a - 16'd1;
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~a;
            4'b1000: r = {15'd0, a == b};
            4'b1001: r = {15'd0, a < b};
            4'b1010: r = {15'd0, a > b};
            4'b1011: r = {15'd0, $signed(a) < $signed(b)};
            4'b1100: r = a << s;
            4'b1101: r = a >> s;
            4'b1110: r = $signed(a) >>> s;
            default: r = (s == 0) ? a : ((a << s) | (a >> (16 - s)));
        endcase
        return r;
    endfunction

    // Unit models: one registered stage, garbage out when flag is withheld
    always @(posedge CLK_in) begin
        for (int u = 0; u < 4; u++) begin
            if (en[u])
                uo[u] <= flag_mode[u] ?
                    ref_op({2'(u), alu_fun_out[1:0]}, A_out, B_out) : 16'hBEEF;
        end
        uf <= en & flag_mode;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] fun, input logic flg,
                           input int hold);
        logic [15:0] exp_d;
        logic [3:0]  exp_en;
        int          cyc;
        int          en_cnt;
        exp_d  = flg ? ref_op(fun, a, b) : 16'h0000;
        exp_en = 4'b0001 << fun[3:2];
        flag_mode = {4{flg}};
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            @(posedge CLK_in); #1; cyc++;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_A = a; cmd_B = b; cmd_fun = fun; cmd_valid = 1'b1;
        @(posedge CLK_in); #1;
        cmd_valid = 1'b0;
        chk("a_out", A_out, a);
        chk("b_out", B_out, b);
        chk("fun_out", alu_fun_out, fun);
        cyc = 0;
        en_cnt = 0;
        while (!res_valid && cyc < 20) begin
            if (en == exp_en) en_cnt++;
            else chk("en_onehot", en, exp_en);
            @(posedge CLK_in); #1; cyc++;
        end
        chk("latency", cyc, 2);
        chk("en_cycles", en_cnt, 2);
        chk("res_data", res_data, exp_d);
        chk("res_unit", res_unit, fun[3:2]);
        chk("res_err", res_err, !flg);
        chk("en_off_hold", en, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK_in); #1;
            chk("hold_stable", {res_valid, res_err, res_unit, res_data},
                {1'b1, !flg, fun[3:2], exp_d});
            chk("hold_ready", cmd_ready, SKID);
            chk("hold_en", en, 0);
        end
        res_ready = 1'b1;
        @(posedge CLK_in); #1;
        res_ready = 1'b0;
        chk("hs_valid", res_valid, 0);
        chk("hs_err", res_err, 0);
        chk("hs_ready", cmd_ready, 1);
    endtask

    initial begin
        bit saw;
        int cyc;

        // Reset asserted mid-cycle
        @(posedge CLK_in); #4;
        RST_in = 1'b1;
        #1;
        chk("rst_ops", {A_out, B_out}, 0);
        chk("rst_misc", {alu_fun_out, en, res_valid, res_unit, res_err}, 0);
        chk("rst_data", res_data, 0);
        chk("rst_ready", cmd_ready, 1);
        repeat (2) @(posedge CLK_in);
        #1 RST_in = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(posedge CLK_in); #1;
            if (res_valid) saw = 1'b1;
        end
        chk("rst_no_valid", saw, 0);

        run_cmd(16'h00FF, 16'h0F0F, 4'b0100, 1'b1, 0);
        run_cmd(16'h1234, 16'h0101, 4'b0000, 1'b1, 5);
        run_cmd(16'h5555, 16'h5555, 4'b1000, 1'b0, 1);

        // Reset while waiting on a unit
        flag_mode = 4'hF;
        cmd_A = 16'h0003; cmd_B = 16'h0004; cmd_fun = 4'b0000;
        cmd_valid = 1'b1;
        @(posedge CLK_in); #1;
        cmd_valid = 1'b0;
        @(posedge CLK_in); #2;
        RST_in = 1'b1;
        #1;
        chk("rstw_en", en, 0);
        chk("rstw_ready", cmd_ready, 1);
        chk("rstw_valid", res_valid, 0);
        @(posedge CLK_in); #1;
        RST_in = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(posedge CLK_in); #1;
            if (res_valid) saw = 1'b1;
        end
        chk("rstw_no_result", saw, 0);
        run_cmd(16'h0010, 16'h0001, 4'b0001, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            run_cmd(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3));
        end

`ifdef ALU_CMD_SKID_EN
        flag_mode = 4'hF;
        cmd_A = 16'h00FF; cmd_B = 16'h0F0F; cmd_fun = 4'b0100;
        cmd_valid = 1'b1;
        @(posedge CLK_in); #1;
        cmd_A = 16'h1234; cmd_B = 16'h0004; cmd_fun = 4'b1101;
        chk("skid_ready_wait", cmd_ready, 1);
        @(posedge CLK_in); #1;
        cmd_A = 16'hAAAA; cmd_B = 16'h0001; cmd_fun = 4'b0000;
        chk("skid_refuse", cmd_ready, 0);
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            @(posedge CLK_in); #1; cyc++;
        end
        cmd_valid = 1'b0;
        chk("skid_r1_data", res_data, 16'h000F);
        chk("skid_r1_unit", res_unit, 2'b01);
        res_ready = 1'b1;
        @(posedge CLK_in); #1;
        res_ready = 1'b0;
        chk("skid_issue_en", en, 4'b1000);
        chk("skid_issue_valid", res_valid, 0);
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            @(posedge CLK_in); #1; cyc++;
        end
        chk("skid_r2_lat", cyc, 2);
        chk("skid_r2_data", res_data, 16'h0123);
        chk("skid_r2_unit", res_unit, 2'b11);
        res_ready = 1'b1;
        @(posedge CLK_in); #1;
        res_ready = 1'b0;
        chk("skid_r2_hs", res_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_dispatcher.md
Name: alu_op_dispatcher

Overview:
- Command-side initiator for the 16-bit ALU function units (arith, logic, cmp, shift).
- Accepts one operation per valid/ready handshake and decodes alu_fun[3:2] into a one-hot unit enable.
- Drives the shared operand/function bus for the selected unit, waits its fixed registered latency, then captures that unit's out/flag.
- Returns the captured result to the upstream consumer through a valid/ready result port.

Parameters:
Data_In_Width, 16, operand/result width in bits.
Unit_Latency, 1, clock edges from enable-high to valid unit out/flag; legal range >= 1.

Ports:
CLK_in  input  1  single system clock, rising edge.
RST_in  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  dispatcher can accept a command.
cmd_A  input  Data_In_Width  operand A.
cmd_B  input  Data_In_Width  operand B.
cmd_fun  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit op.
A_out  output  Data_In_Width  operand A to all units.
B_out  output  Data_In_Width  operand B to all units.
alu_fun_out  output  4  latched cmd_fun to all units.
arith_En, logic_En, cmp_En, shift_En  output  1 each  one-hot unit enables.
arith_out, logic_out, cmp_out, shift_out  input  Data_In_Width each  unit results.
arith_flag, logic_flag, cmp_flag, shift_flag  input  1 each  unit result-valid flags.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_data  output  Data_In_Width  captured result.
res_unit  output  2  unit that produced res_data.
res_err  output  1  selected unit's flag was 0 at capture.

Behaviour:
- Reset: all registered outputs and registers go to 0 (A_out, B_out, alu_fun_out, enables, res_*, wait counter); state goes to IDLE.
  - cmd_ready=1 during and after reset, because it is derived from state==IDLE.
  - A command in flight when reset asserts is dropped; no result is produced for it.
- State machine: IDLE, WAIT, HOLD.
- IDLE:
  - cmd_ready=1; all enables are 0.
  - On the edge where cmd_valid&&cmd_ready: latch cmd_A/cmd_B/cmd_fun into A_out/B_out/alu_fun_out.
  - On the same edge: set the enable selected by cmd_fun[3:2], load the counter with Unit_Latency, and go to WAIT.
- WAIT:
  - cmd_ready=0. The enable and operands are held stable for the whole state.
  - The counter decrements once per edge.
  - On the edge where counter==0: capture the selected unit's out/flag through the mux, clear all enables, and go to HOLD.
- Capture:
  - flag=1 gives res_data=unit out, res_err=0.
  - flag=0 gives res_data=0, res_err=1.
  - res_unit=alu_fun_out[3:2]; res_valid=1.
- Latency: the enable is high for Unit_Latency+1 cycles. res_valid rises Unit_Latency+1 cycles after the accept edge (2 cycles at the default).
- HOLD:
  - res_valid, res_data, res_unit and res_err are held stable while res_ready=0; cmd_ready=0.
  - On res_valid&&res_ready: clear res_valid and go to IDLE.
- Throughput without the optional feature: one command per Unit_Latency+3 cycles when res_ready is held high.
- Only one enable is ever high. A_out/B_out/alu_fun_out keep their last value while idle.
- res_err clears on the result handshake.

Optional Feature:
- Macro ALU_CMD_SKID_EN.
- Defined:
  - Adds a one-entry command holding register; cmd_ready = !skid_full in every state.
  - A command accepted in WAIT or HOLD is stored in the holding register.
  - On the HOLD result-handshake edge, a stored command issues directly (HOLD->WAIT, enable set on that edge) and the holding register empties.
  - If the holding register is empty and cmd_valid is high on that edge, the incoming command issues directly instead.
  - Reset empties the holding register.
- Undefined: behaviour is exactly as described above; cmd_ready=(state==IDLE).

Decomposition:
- Package alu_pkg holds:
  - unit-select encodings (UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11);
  - state encoding constants;
  - default width 16.
- One sub-module, alu_result_mux: combinational 4:1 selection of out/flag by the 2-bit unit select. It is shared with any future result consumer.

Test Plan:
- Reset: assert RST_in mid-cycle -> all outputs 0 immediately, cmd_ready=1, no res_valid after release.
- Logic AND: A=16'h00FF, B=16'h0F0F, fun=4'b0100, bench unit model at latency 1 -> logic_En high 2 cycles, res_valid at accept+2, res_data=16'h000F, res_unit=2'b01, res_err=0.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_* stable, cmd_ready=0, all enables 0; res_ready=1 -> IDLE and cmd_ready=1 on the next cycle.
- Missing flag: cmp model drives cmp_flag=0, out=16'hBEEF -> res_err=1, res_data=16'h0000, res_unit=2'b10.
- Reset in WAIT: assert RST_in one cycle after accept -> enables drop asynchronously, no result is ever presented, the next command completes normally.
- ALU_CMD_SKID_EN: second cmd (shift, fun=4'b1101) during WAIT accepted, third refused (cmd_ready=0) -> shift_En rises on the first result-handshake edge, results arrive in order.
